// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared definitions for the serial bus slave/master ports:
//               slave FSM state encoding, default field widths and the
//               instruction codes exchanged with the master port.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Default field widths (bits per serial frame field)
  localparam int DEF_SLAVE_ADDR_SIZE = 12;
  localparam int DEF_WORD_SIZE       = 8;
  localparam int DEF_BURST_SIZE      = 15;

  // Instruction codes shared with the master port
  localparam logic [1:0] INSTR_WRITE      = 2'b01;
  localparam logic [1:0] INSTR_READ       = 2'b10;
  localparam logic [1:0] INSTR_BURST_READ = 2'b11;

  // Slave input port FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_RX   = 3'd1,
    CMD_WAIT  = 3'd2,
    BURST_RX  = 3'd3,
    DATA_RX   = 3'd4,
    READ_REQ  = 3'd5,
    READ_WAIT = 3'd6
  } slave_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_deser.sv
`default_nettype none
// ============================================================================
// Module      : serial_deser
// Description : LSB-first serial-to-parallel deserialiser. Each enabled
//               sample writes bit_in at the position given by the bit
//               counter. done flags (combinationally) the edge on which the
//               final bit is captured; word presents the value including
//               the bit being sampled so the caller can latch it that edge.
// Ports       : clk, rst       - clock, async active-high reset
//               sample_en      - capture bit_in on this edge
//               clear          - reset counter and shift register
//               bit_in         - serial data bit
//               word [WIDTH]   - assembled word (including current bit)
//               done           - final bit captured on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clear,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done    = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (sample_en) begin
      shift_d[cnt_q] = bit_in;
      if (cnt_q == C_LAST) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign word = shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/slave_in_port.sv
`default_nettype none
// ============================================================================
// Module      : slave_in_port
// Description : Serial bus slave input port. Receives an address frame, then
//               either a burst length (burst read), a single-read request,
//               or a stream of write words, and converts them into parallel
//               write pulses / read requests for the local memory.
// Ports       : clk, rst                  - clock, async active-high reset
//               slave_select              - slave selected by master
//               addr_bus/burst_size_bus/w_data_bus - serial inputs, LSB first
//               m_valid/m_b_tx_valid/read_en - command qualifiers
//               tx_done/split_on          - end / abandon transaction
//               mem_ready/rd_done         - local memory handshakes
//               s_ready                   - slave can sample a bit
//               addr/burst_len/wr_data    - assembled fields
//               wr_valid/wr_addr_offset   - write word pulse and index
//               rd_req/rd_len             - read start pulse and length
//               busy                      - transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module slave_in_port
  import bus_pkg::*;
#(
  parameter int SLAVE_ADDR_SIZE = DEF_SLAVE_ADDR_SIZE,
  parameter int WORD_SIZE       = DEF_WORD_SIZE,
  parameter int BURST_SIZE      = DEF_BURST_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       slave_select,
  input  logic                       addr_bus,
  input  logic                       burst_size_bus,
  input  logic                       w_data_bus,
  input  logic                       m_valid,
  input  logic                       m_b_tx_valid,
  input  logic                       read_en,
  input  logic                       tx_done,
  input  logic                       split_on,
  input  logic                       mem_ready,
  input  logic                       rd_done,
  output logic                       s_ready,
  output logic [SLAVE_ADDR_SIZE-1:0] addr,
  output logic [BURST_SIZE-1:0]      burst_len,
  output logic [WORD_SIZE-1:0]       wr_data,
  output logic                       wr_valid,
  output logic [BURST_SIZE-1:0]      wr_addr_offset,
  output logic                       rd_req,
  output logic [BURST_SIZE-1:0]      rd_len,
  output logic                       busy
);

  slave_state_t state_q, state_d;

  logic [SLAVE_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [BURST_SIZE-1:0]      burst_len_q, burst_len_d;
  logic [WORD_SIZE-1:0]       wr_data_q, wr_data_d;
  logic                       wr_valid_q, wr_valid_d;
  logic [BURST_SIZE-1:0]      wr_addr_offset_q, wr_addr_offset_d;
  logic [BURST_SIZE-1:0]      idx_q, idx_d;
  logic                       rd_req_q, rd_req_d;
  logic [BURST_SIZE-1:0]      rd_len_q, rd_len_d;
  logic                       busy_q, busy_d;

  logic                       sample;
  logic                       abort;
  logic                       deser_clear;
  logic [SLAVE_ADDR_SIZE-1:0] addr_word;
  logic [BURST_SIZE-1:0]      burst_word;
  logic [WORD_SIZE-1:0]       data_word;
  logic                       addr_done, burst_done, data_done;

  assign s_ready = mem_ready && (state_q != READ_REQ) && (state_q != READ_WAIT);
  assign sample  = slave_select && s_ready;
  // Deselect is ignored while waiting for the read-out side to finish.
  assign abort   = split_on || (!slave_select && (state_q != READ_WAIT));
  // Deserialisers restart from bit 0 for every new frame.
  assign deser_clear = (state_q == IDLE);

  serial_deser #(.WIDTH(SLAVE_ADDR_SIZE)) u_addr_deser (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample && (state_q == ADDR_RX)),
    .clear     (deser_clear),
    .bit_in    (addr_bus),
    .word      (addr_word),
    .done      (addr_done)
  );

  serial_deser #(.WIDTH(BURST_SIZE)) u_burst_deser (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample && (state_q == BURST_RX)),
    .clear     (deser_clear),
    .bit_in    (burst_size_bus),
    .word      (burst_word),
    .done      (burst_done)
  );

  serial_deser #(.WIDTH(WORD_SIZE)) u_data_deser (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample && (state_q == DATA_RX)),
    .clear     (deser_clear),
    .bit_in    (w_data_bus),
    .word      (data_word),
    .done      (data_done)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    burst_len_d      = burst_len_q;
    wr_data_d        = wr_data_q;
    wr_valid_d       = 1'b0;
    wr_addr_offset_d = wr_addr_offset_q;
    idx_d            = idx_q;
    rd_req_d         = 1'b0;
    rd_len_d         = rd_len_q;

    if (state_q == IDLE) begin
      idx_d = '0;
      if (slave_select) begin
        state_d = ADDR_RX;
      end
    end else if (abort) begin
      // Partial address/word is dropped; registered fields keep their
      // last complete values.
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR_RX: begin
          if (addr_done) begin
            addr_d  = addr_word;
            state_d = CMD_WAIT;
          end
        end
        CMD_WAIT: begin
          if (m_b_tx_valid) begin
            state_d = BURST_RX;
          end else if (read_en) begin
            rd_len_d = BURST_SIZE'(1);
            state_d  = READ_REQ;
          end else if (m_valid) begin
            state_d = DATA_RX;
          end
        end
        BURST_RX: begin
          if (burst_done) begin
            burst_len_d = burst_word;
            rd_len_d    = (burst_word == '0) ? BURST_SIZE'(1) : burst_word;
            state_d     = READ_REQ;
          end
        end
        DATA_RX: begin
          // A word completing on the tx_done edge is still delivered.
          if (data_done) begin
            wr_valid_d       = 1'b1;
            wr_data_d        = data_word;
            wr_addr_offset_d = idx_q;
            idx_d            = idx_q + 1'b1;
          end
          if (tx_done) begin
            state_d = IDLE;
          end
        end
        READ_REQ: begin
          rd_req_d = 1'b1;
          state_d  = READ_WAIT;
        end
        READ_WAIT: begin
          if (rd_done) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      burst_len_q      <= '0;
      wr_data_q        <= '0;
      wr_valid_q       <= 1'b0;
      wr_addr_offset_q <= '0;
      idx_q            <= '0;
      rd_req_q         <= 1'b0;
      rd_len_q         <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      burst_len_q      <= burst_len_d;
      wr_data_q        <= wr_data_d;
      wr_valid_q       <= wr_valid_d;
      wr_addr_offset_q <= wr_addr_offset_d;
      idx_q            <= idx_d;
      rd_req_q         <= rd_req_d;
      rd_len_q         <= rd_len_d;
      busy_q           <= busy_d;
    end
  end

  assign addr           = addr_q;
  assign burst_len      = burst_len_q;
  assign wr_data        = wr_data_q;
  assign wr_valid       = wr_valid_q;
  assign wr_addr_offset = wr_addr_offset_q;
  assign rd_req         = rd_req_q;
  assign rd_len         = rd_len_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_slave_in_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_in_port
// Description : Directed self-checking bench for slave_in_port. Inputs are
//               driven on the falling edge, outputs observed on the falling
//               edge after the rising edge that updates them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_in_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_select, addr_bus, burst_size_bus, w_data_bus;
  logic        m_valid, m_b_tx_valid, read_en, tx_done, split_on;
  logic        mem_ready, rd_done;
  logic        s_ready;
  logic [11:0] addr;
  logic [14:0] burst_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic [14:0] wr_addr_offset;
  logic        rd_req;
  logic [14:0] rd_len;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0]  log_data[$];
  logic [14:0] log_off[$];

  always #5 clk = ~clk;

  slave_in_port dut (
    .clk            (clk),
    .rst            (rst),
    .slave_select   (slave_select),
    .addr_bus       (addr_bus),
    .burst_size_bus (burst_size_bus),
    .w_data_bus     (w_data_bus),
    .m_valid        (m_valid),
    .m_b_tx_valid   (m_b_tx_valid),
    .read_en        (read_en),
    .tx_done        (tx_done),
    .split_on       (split_on),
    .mem_ready      (mem_ready),
    .rd_done        (rd_done),
    .s_ready        (s_ready),
    .addr           (addr),
    .burst_len      (burst_len),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_addr_offset (wr_addr_offset),
    .rd_req         (rd_req),
    .rd_len         (rd_len),
    .busy           (busy)
  );

  // Pulse monitor: each one-cycle pulse is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wr_cnt++;
      log_data.push_back(wr_data);
      log_off.push_back(wr_addr_offset);
    end
    if (rd_req === 1'b1) rd_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    slave_select = 0; addr_bus = 0; burst_size_bus = 0; w_data_bus = 0;
    m_valid = 0; m_b_tx_valid = 0; read_en = 0; tx_done = 0;
    split_on = 0; mem_ready = 1; rd_done = 0;
  endtask

  task automatic settle();
    @(negedge clk) drive_idle();
    repeat (2) @(negedge clk);
  endtask

  // Select the slave and shift a 12-bit address; returns on the falling
  // edge before the rising edge that samples the last bit.
  task automatic start_frame(input logic [11:0] a);
    @(negedge clk) slave_select = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk) addr_bus = a[i];
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic last_tx);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) w_data_bus = w[i];
      tx_done = last_tx && (i == 7);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({addr, burst_len, wr_data, wr_valid, wr_addr_offset, rd_req, rd_len, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h bl=%h wd=%h wv=%b off=%h rq=%b rl=%h busy=%b, need all 0",
               addr, burst_len, wr_data, wr_valid, wr_addr_offset, rd_req, rd_len, busy);
    end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b need 1", s_ready); end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int base = wr_cnt;
    start_frame(12'hA5C);
    @(negedge clk) m_valid = 1;
    send_word(8'h3B, 1'b0);
    @(negedge clk) tx_done = 1; w_data_bus = 0;
    checks++;
    if (wr_valid !== 1'b1 || wr_data !== 8'h3B) begin
      errors++; $display("FAIL write_pulse: got wv=%b wd=%h need 1/3b", wr_valid, wr_data);
    end
    checks++;
    if (addr !== 12'hA5C || wr_addr_offset !== 15'd0) begin
      errors++; $display("FAIL write_addr: got addr=%h off=%0d need a5c/0", addr, wr_addr_offset);
    end
    @(negedge clk) drive_idle();
    #1;
    checks++;
    if (busy !== 1'b0 || wr_valid !== 1'b0) begin
      errors++; $display("FAIL write_idle: got busy=%b wv=%b need 0/0", busy, wr_valid);
    end
    settle();
    checks++;
    if (wr_cnt - base != 1) begin errors++; $display("FAIL write_count: got %0d need 1", wr_cnt - base); end
  endtask

  task automatic test_burst_read(input logic [14:0] bl, input logic [14:0] exp_len);
    int base = rd_cnt;
    start_frame(12'h010);
    @(negedge clk) m_b_tx_valid = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk) m_b_tx_valid = 0; burst_size_bus = bl[i];
    end
    @(negedge clk) burst_size_bus = 0;
    #1;
    checks++;
    if (rd_len !== exp_len || burst_len !== bl || rd_req !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL burst_req_setup: got rl=%0d bl=%0d rq=%b sr=%b need %0d/%0d/0/0",
                         rd_len, burst_len, rd_req, s_ready, exp_len, bl);
    end
    @(negedge clk);
    checks++;
    if (rd_req !== 1'b1 || addr !== 12'h010) begin
      errors++; $display("FAIL burst_rd_req: got rq=%b addr=%h need 1/010", rd_req, addr);
    end
    @(negedge clk) slave_select = 0;
    checks++;
    if (rd_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL burst_wait: got rq=%b busy=%b need 0/1", rd_req, busy);
    end
    @(negedge clk) rd_done = 1;
    @(negedge clk) rd_done = 0;
    checks++;
    if (busy !== 1'b0 || rd_cnt - base != 1) begin
      errors++; $display("FAIL burst_done: got busy=%b pulses=%0d need 0/1", busy, rd_cnt - base);
    end
    settle();
  endtask

  task automatic test_stall();
    logic [11:0] a = 12'h6C3;
    @(negedge clk) slave_select = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) addr_bus = a[i];
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk) mem_ready = 0; addr_bus = ~a[5];
      #1;
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready: cycle %0d got %b need 0", c, s_ready); end
    end
    @(negedge clk) mem_ready = 1; addr_bus = a[5];
    for (int i = 6; i < 12; i++) begin
      @(negedge clk) addr_bus = a[i];
    end
    @(negedge clk) read_en = 1;
    @(negedge clk) read_en = 0;
    checks++;
    if (addr !== 12'h6C3 || rd_len !== 15'd1) begin
      errors++; $display("FAIL stall_addr: got addr=%h rl=%0d need 6c3/1", addr, rd_len);
    end
    @(negedge clk);
    @(negedge clk) rd_done = 1;
    @(negedge clk) rd_done = 0;
    settle();
  endtask

  task automatic test_three_words_deselect();
    int base = wr_cnt;
    log_data.delete(); log_off.delete();
    start_frame(12'h123);
    @(negedge clk) m_valid = 1;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) w_data_bus = i[0];
    end
    @(negedge clk) slave_select = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL desel_idle: got busy=%b need 0", busy); end
    settle();
    checks++;
    if (wr_cnt - base != 2) begin
      errors++; $display("FAIL desel_count: got %0d need 2", wr_cnt - base);
    end else begin
      checks++;
      if (log_data[0] !== 8'h11 || log_off[0] !== 15'd0 || log_data[1] !== 8'h22 || log_off[1] !== 15'd1) begin
        errors++; $display("FAIL desel_words: got %h@%0d %h@%0d need 11@0 22@1",
                           log_data[0], log_off[0], log_data[1], log_off[1]);
      end
    end
  endtask

  task automatic test_tx_done_on_last_bit();
    int base = wr_cnt;
    start_frame(12'h0F0);
    @(negedge clk) m_valid = 1;
    send_word(8'h5A, 1'b1);
    @(negedge clk) drive_idle();
    checks++;
    if (wr_valid !== 1'b1 || wr_data !== 8'h5A || busy !== 1'b0) begin
      errors++; $display("FAIL lastbit_txdone: got wv=%b wd=%h busy=%b need 1/5a/0", wr_valid, wr_data, busy);
    end
    settle();
    checks++;
    if (wr_cnt - base != 1) begin errors++; $display("FAIL lastbit_count: got %0d need 1", wr_cnt - base); end
  endtask

  task automatic test_split();
    int base = wr_cnt;
    start_frame(12'h3AA);
    @(negedge clk) m_valid = 1;
    send_word(8'h99, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) w_data_bus = 1;
    end
    @(negedge clk) split_on = 1; w_data_bus = 1;
    @(negedge clk) split_on = 0;
    checks++;
    if (busy !== 1'b0 || addr !== 12'h3AA) begin
      errors++; $display("FAIL split_idle: got busy=%b addr=%h need 0/3aa", busy, addr);
    end
    settle();
    checks++;
    if (wr_cnt - base != 1) begin errors++; $display("FAIL split_count: got %0d need 1", wr_cnt - base); end
  endtask

  task automatic test_reset_mid_data();
    int base;
    start_frame(12'h7E1);
    @(negedge clk) m_valid = 1;
    send_word(8'h77, 1'b0);
    @(negedge clk) w_data_bus = 1;
    #2 rst = 1;
    #1;
    base = wr_cnt;
    checks++;
    if ({addr, burst_len, wr_data, wr_valid, wr_addr_offset, rd_req, rd_len, busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid_data: got addr=%h wd=%h wv=%b busy=%b need all 0", addr, wr_data, wr_valid, busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) w_data_bus = ~w_data_bus;
    end
    @(negedge clk) rst = 0; drive_idle();
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt != base || busy !== 1'b0) begin
      errors++; $display("FAIL rst_no_pulse: got pulses=%0d busy=%b need 0/0", wr_cnt - base, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_read(15'd5, 15'd5);
    test_burst_read(15'd0, 15'd1);
    test_stall();
    test_three_words_deselect();
    test_tx_done_on_last_bit();
    test_split();
    test_reset_mid_data();
    test_single_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
